// File: rtl/rate_mult_bank.sv
// rate_mult_bank: bank of rate multipliers sharing one period counter.
// Each tick advances the counter. The counter's trailing-ones pattern picks one
// stage, and each channel's rate bit for that stage decides whether it pulses.
// Rate words are double-buffered: a write lands in a pending register and is
// committed to the active rate at the next period wrap or sync.
// Optional feature: define RATE_MULT_BANK_PCNT_EN to add per-channel
// saturating pulse counters on the pulse_cnt output.
module rate_mult_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                sync,
    input  logic                rate_wr_valid,
    input  logic [CH_W-1:0]     rate_wr_ch,
    input  logic [WIDTH-1:0]    rate_wr_data,
    output logic                rate_wr_ready,
    output logic [CHANNELS-1:0] out_pulse,
    output logic                period_done
`ifdef RATE_MULT_BANK_PCNT_EN
    ,
    output logic [CHANNELS*16-1:0] pulse_cnt
`endif
);

    logic [WIDTH-1:0]                 cnt_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   active_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   pending_q;
    logic [CHANNELS-1:0]              pend_q;
    logic [CHANNELS-1:0]              out_pulse_q;
    logic [CHANNELS-1:0]              out_pulse_d;
    logic [CHANNELS-1:0]              wr_accept;
    logic                             period_done_q;
    logic                             period_done_d;
    logic [WIDTH-1:0]                 stage_fire;
    logic                             ones_below;

    // Stage k fires when bit k is the lowest zero of the counter; all ones fires nothing.
    always_comb begin
        stage_fire = '0;
        ones_below = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            stage_fire[k] = ones_below & ~cnt_q[k];
            ones_below    = ones_below & cnt_q[k];
        end
    end

    // Stage k is weighted by rate bit WIDTH-1-k, so the MSB fires every other tick.
    always_comb begin
        out_pulse_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int k = 0; k < WIDTH; k++) begin
                out_pulse_d[ch] = out_pulse_d[ch] | (stage_fire[k] & active_q[ch][WIDTH-1-k]);
            end
        end
    end

    // Write handshake: a channel accepts only while its pending slot is free; out-of-range channels are always ready and ignored.
    always_comb begin
        rate_wr_ready = 1'b1;
        wr_accept     = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (rate_wr_ch == CH_W'(ch)) begin
                rate_wr_ready = ~pend_q[ch];
                wr_accept[ch] = rate_wr_valid & ~pend_q[ch];
            end
        end
    end

    assign period_done_d = tick & ~sync & (&cnt_q);

    // Counter, commit and output registers; sync beats tick, and a write landing in a commit cycle waits for the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            pend_q        <= '0;
            out_pulse_q   <= '0;
            period_done_q <= 1'b0;
        end else begin
            out_pulse_q   <= '0;
            period_done_q <= 1'b0;
            if (sync) begin
                cnt_q <= '0;
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    if (pend_q[ch]) begin
                        active_q[ch] <= pending_q[ch];
                    end
                end
                pend_q <= '0;
            end else if (tick) begin
                cnt_q       <= cnt_q + 1'b1;
                out_pulse_q <= out_pulse_d;
                if (period_done_d) begin
                    period_done_q <= 1'b1;
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        if (pend_q[ch]) begin
                            active_q[ch] <= pending_q[ch];
                        end
                    end
                    pend_q <= '0;
                end
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (wr_accept[ch]) begin
                    pending_q[ch] <= rate_wr_data;
                    pend_q[ch]    <= 1'b1;
                end
            end
        end
    end

    assign out_pulse   = out_pulse_q;
    assign period_done = period_done_q;

`ifdef RATE_MULT_BANK_PCNT_EN
    logic [CHANNELS-1:0][15:0] pcnt_q;

    // Per-channel pulse counters that stick at full scale until reset or sync.
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            pcnt_q <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (out_pulse_q[ch] && (pcnt_q[ch] != 16'hFFFF)) begin
                    pcnt_q[ch] <= pcnt_q[ch] + 16'd1;
                end
            end
        end
    end

    assign pulse_cnt = pcnt_q;
`else
    // Counter-less build: no pulse_cnt port and no counter state.
`endif

endmodule

// File: tb/tb_rate_mult_bank.sv
// tb_rate_mult_bank: self-checking bench for rate_mult_bank (WIDTH=8, CHANNELS=2).
// Combines a directed vector table, hand-written period sequences and random
// stimulus, all checked against a behavioural model of the rate rules.
// Define RATE_MULT_BANK_PCNT_EN to also exercise the pulse counters.
module tb_rate_mult_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int CH_W     = 1;
    localparam int PERIOD   = 256;

    logic                clk;
    logic                rst;
    logic                tick;
    logic                sync;
    logic                rate_wr_valid;
    logic [CH_W-1:0]     rate_wr_ch;
    logic [WIDTH-1:0]    rate_wr_data;
    logic                rate_wr_ready;
    logic [CHANNELS-1:0] out_pulse;
    logic                period_done;
`ifdef RATE_MULT_BANK_PCNT_EN
    logic [CHANNELS*16-1:0] pulse_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         mcnt;
    logic [7:0] mact [CHANNELS];
    logic [7:0] mpnd [CHANNELS];
    bit         mpend [CHANNELS];
    logic [1:0] mout;
    bit         mpd;
    int         mpc [CHANNELS];
    bit         mvalid = 0;
    logic       ready_seen;

    rate_mult_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .sync          (sync),
        .rate_wr_valid (rate_wr_valid),
        .rate_wr_ch    (rate_wr_ch),
        .rate_wr_data  (rate_wr_data),
        .rate_wr_ready (rate_wr_ready),
        .out_pulse     (out_pulse),
        .period_done   (period_done)
`ifdef RATE_MULT_BANK_PCNT_EN
        ,
        .pulse_cnt     (pulse_cnt)
`endif
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Number of consecutive ones starting at the LSB of a counter value
    function automatic int trailOnes(input int c);
        int k = 0;
        while ((c % 2 == 1) && (k < WIDTH)) begin
            c = c / 2;
            k++;
        end
        return k;
    endfunction

    // Advance the model by one clock edge with the given inputs
    task automatic modelUpdate(input logic r, t, s, wv, input int wch, input logic [7:0] wd);
        logic [1:0] nout;
        bit accept;
        int k;
        nout = 2'b00;
        if (r) begin
            mcnt = 0; mout = 2'b00; mpd = 0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                mact[ch] = 8'h00; mpnd[ch] = 8'h00; mpend[ch] = 0; mpc[ch] = 0;
            end
            return;
        end
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (s) mpc[ch] = 0;
            else if (mout[ch] && mpc[ch] < 65535) mpc[ch] = mpc[ch] + 1;
        end
        accept = wv && (wch < CHANNELS) && !mpend[wch];
        mpd = 0;
        if (s) begin
            mcnt = 0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (mpend[ch]) mact[ch] = mpnd[ch];
                mpend[ch] = 0;
            end
        end else if (t) begin
            k = trailOnes(mcnt);
            if (k < WIDTH) begin
                for (int ch = 0; ch < CHANNELS; ch++) nout[ch] = mact[ch][WIDTH-1-k];
            end
            if (mcnt == PERIOD - 1) begin
                mpd = 1;
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    if (mpend[ch]) mact[ch] = mpnd[ch];
                    mpend[ch] = 0;
                end
            end
            mcnt = (mcnt + 1) % PERIOD;
        end
        if (accept) begin
            mpnd[wch] = wd;
            mpend[wch] = 1;
        end
        mout = nout;
    endtask

    task automatic checkOutput();
        check("out_pulse", 32'(out_pulse), 32'(mout));
        check("period_done", 32'(period_done), 32'(mpd));
`ifdef RATE_MULT_BANK_PCNT_EN
        check("pulse_cnt0", 32'(pulse_cnt[15:0]), 32'(mpc[0]));
        check("pulse_cnt1", 32'(pulse_cnt[31:16]), 32'(mpc[1]));
`endif
    endtask

    // One clock cycle: drive, check ready mid-cycle, clock, update model, check outputs
    task automatic applyStimulus(input logic r, t, s, wv, input logic [0:0] wch, input logic [7:0] wd);
        logic expReady;
        rst = r; tick = t; sync = s;
        rate_wr_valid = wv; rate_wr_ch = wch; rate_wr_data = wd;
        @(negedge clk);
        ready_seen = rate_wr_ready;
        if (mvalid) begin
            expReady = (int'(wch) >= CHANNELS) ? 1'b1 : !mpend[wch];
            check("rate_wr_ready", 32'(ready_seen), 32'(expReady));
        end
        @(posedge clk);
        modelUpdate(r, t, s, wv, int'(wch), wd);
        if (r) mvalid = 1;
        #1;
        checkOutput();
    endtask

    task automatic doTick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic doWrite(input logic [0:0] ch, input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, ch, d);
    endtask

    typedef struct packed {
        logic       r, t, s, wv;
        logic [0:0] wch;
        logic [7:0] wd;
        logic       er;
        logic [1:0] eo;
        logic       ep;
    } vec_t;

    vec_t tbl [14];
    int c0, c1, npd, pdAt, c1At;
    bit readyHeld;

    initial begin
        rst = 1'b1; tick = 1'b0; sync = 1'b0;
        rate_wr_valid = 1'b0; rate_wr_ch = '0; rate_wr_data = '0;

        // Directed vectors from a clean reset
        //          r    t    s    wv   ch    data   ready out    pd
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 8'h80, 1'b1, 2'b00, 1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 8'h40, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 1'b0, 2'b00, 1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00, 1'b1, 2'b01, 1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00, 1'b1, 2'b00, 1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00, 1'b1, 2'b01, 1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 1'b1, 2'b00, 1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b1, 8'h40, 1'b1, 2'b00, 1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b1, 8'h01, 1'b0, 2'b01, 1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 8'h00, 1'b0, 2'b00, 1'b0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 8'h00, 1'b1, 2'b01, 1'b0};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 8'h00, 1'b1, 2'b10, 1'b0};
        tbl[12] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 8'h11, 1'b1, 2'b00, 1'b0};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 8'h00, 1'b1, 2'b00, 1'b0};

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_out_pulse", 32'(out_pulse), 32'd0);
        check("reset_period_done", 32'(period_done), 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].wv, tbl[i].wch, tbl[i].wd);
            check($sformatf("vec%0d_ready", i), 32'(ready_seen), 32'(tbl[i].er));
            check($sformatf("vec%0d_out", i), 32'(out_pulse), 32'(tbl[i].eo));
            check($sformatf("vec%0d_pd", i), 32'(period_done), 32'(tbl[i].ep));
        end

        // Full period with ch0=0xB4, ch1=0x00
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        doWrite(1'b0, 8'hB4);
        doWrite(1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        c0 = 0; c1 = 0; npd = 0; pdAt = -1;
        for (int i = 0; i < PERIOD; i++) begin
            doTick();
            c0 += int'(out_pulse[0]); c1 += int'(out_pulse[1]);
            if (period_done) begin npd++; pdAt = i; end
        end
        check("period_b4_ch0_count", 32'(c0), 32'd180);
        check("period_b4_ch1_count", 32'(c1), 32'd0);
        check("period_done_count", 32'(npd), 32'd1);
        check("period_done_position", 32'(pdAt), 32'd255);

        // Alternate-cycle pulses with ch0=0x80
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        doWrite(1'b0, 8'h80);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            doTick();
            check($sformatf("alt_tick%0d", i), 32'(out_pulse[0]), 32'((i % 2) == 0));
        end

        // Mid-period write of 0xFF over active 0x40
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        doWrite(1'b0, 8'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        c0 = 0; readyHeld = 1;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == 100) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
            else doTick();
            if (i > 100 && ready_seen !== 1'b0) readyHeld = 0;
            c0 += int'(out_pulse[0]);
        end
        check("ready_low_until_wrap", 32'(readyHeld), 32'd1);
        check("period_40_count", 32'(c0), 32'd64);
        c0 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            doTick();
            c0 += int'(out_pulse[0]);
        end
        check("ready_after_wrap", 32'(ready_seen), 32'd1);
        check("period_ff_count", 32'(c0), 32'd255);

        // Write ch1=0x01 in the wrap cycle: deferred one full period
        for (int i = 0; i < PERIOD - 1; i++) doTick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01);
        check("wrap_write_ready", 32'(ready_seen), 32'd1);
        c1 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            doTick();
            c1 += int'(out_pulse[1]);
        end
        check("wrap_write_not_committed", 32'(c1), 32'd0);
        c1 = 0; c1At = -1;
        for (int i = 0; i < PERIOD; i++) begin
            doTick();
            if (out_pulse[1]) begin c1++; c1At = i; end
        end
        check("wrap_write_committed_count", 32'(c1), 32'd1);
        check("wrap_write_pulse_position", 32'(c1At), 32'h7F);

        // Reset in the middle of a period
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        doWrite(1'b0, 8'hFF);
        doWrite(1'b1, 8'hAA);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 50; i++) doTick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("midreset_out", 32'(out_pulse), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("midreset_ready0", 32'(ready_seen), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("midreset_ready1", 32'(ready_seen), 32'd1);
        c0 = 0;
        for (int i = 0; i < 20; i++) begin
            doTick();
            c0 += int'(out_pulse[0]) + int'(out_pulse[1]);
        end
        check("midreset_no_pulses", 32'(c0), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 40) == 0,
                          ($urandom % 3) == 0, 1'($urandom), 8'($urandom));
        end

`ifdef RATE_MULT_BANK_PCNT_EN
        // Pulse counter saturation and clear
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        doWrite(1'b0, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 258 * PERIOD; i++) begin
            rst = 1'b0; tick = 1'b1; sync = 1'b0; rate_wr_valid = 1'b0;
            @(posedge clk);
            modelUpdate(1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("pcnt_saturated", 32'(pulse_cnt[15:0]), 32'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pcnt_sync_clear", 32'(pulse_cnt[15:0]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
